// File: rtl/dcu.sv
// Data cache unit front end: turns single LSU load/store requests into single-beat AXI transactions.
// Optional build macro DCU_ALIGN_CHECK_EN completes misaligned requests locally instead of issuing them.
module dcu (
  input  logic        clock,
  input  logic        reset,
  input  logic        lsu2dcu_valid,
  output logic        dcu2lsu_ready,
  input  logic [31:0] dcu_addr,
  input  logic [1:0]  dcu_size,
  input  logic        dcu_write,
  input  logic        dcu_sext,
  input  logic [31:0] dcu_wdata,
  output logic        dcu2lsu_valid,
  input  logic        lsu2dcu_ready,
  output logic [31:0] dcu_rdata,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic [7:0]  awlen,
  output logic [1:0]  awburst,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic [7:0]  arlen,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_WRESP   = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_DATA = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        write_q, write_d;
  logic        sext_q, sext_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic [1:0]  req_size_s;
  logic        misalign_s;
  logic        resp_fire_s;
  logic        resp_unused_s;

  function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] base;
    case (size)
      2'd0:    base = 4'b0001;
      2'd1:    base = 4'b0011;
      default: base = 4'b1111;
    endcase
    lane_strobe = base << off;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] data, input logic [1:0] off,
                                               input logic [1:0] size, input logic sext);
    logic [31:0] lane;
    lane = data >> {off, 3'b000};
    case (size)
      2'd0:    load_extract = {{24{sext & lane[7]}}, lane[7:0]};
      2'd1:    load_extract = {{16{sext & lane[15]}}, lane[15:0]};
      default: load_extract = data;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    is_misaligned = 1'b0;
      2'd1:    is_misaligned = off[0];
      default: is_misaligned = (off != 2'd0);
    endcase
  endfunction

  // Size code 3 behaves as a word everywhere, so it is folded at capture time.
  assign req_size_s = (dcu_size == 2'd3) ? 2'd2 : dcu_size;

`ifdef DCU_ALIGN_CHECK_EN
  assign misalign_s = is_misaligned(req_size_s, dcu_addr[1:0]);
`else
  assign misalign_s = 1'b0;
`endif

  assign resp_fire_s   = write_q ? (bvalid & bready_q) : (rvalid & rready_q);
  // Error responses do not alter completion, so status and rlast are not consumed.
  assign resp_unused_s = ^{bresp, rresp, rlast};

  // Next-state and next-output computation for the transaction sequencer.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    write_d   = write_q;
    sext_d    = sext_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    ready_d   = ready_q;
    valid_d   = valid_q;
    rdata_d   = rdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    case (state_q)
      S_IDLE: begin
        if (lsu2dcu_valid) begin
          addr_d  = dcu_addr;
          size_d  = req_size_s;
          write_d = dcu_write;
          sext_d  = dcu_sext;
          wdata_d = dcu_wdata << {dcu_addr[1:0], 3'b000};
          wstrb_d = lane_strobe(req_size_s, dcu_addr[1:0]);
          ready_d = 1'b0;
          if (misalign_s) begin
            state_d = S_DONE;
            valid_d = 1'b1;
            rdata_d = 32'd0;
          end else if (dcu_write) begin
            state_d   = S_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_RD_ADDR;
            arvalid_d = 1'b1;
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      S_WR: begin
        // AW and W retire independently; the response phase starts once both have.
        awvalid_d = awvalid_q & ~awready;
        wvalid_d  = wvalid_q & ~wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = S_WRESP;
          bready_d = 1'b1;
        end else begin
          state_d = S_WR;
        end
      end
      S_RD_ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end else begin
          arvalid_d = 1'b1;
        end
      end
      S_WRESP, S_RD_DATA: begin
        if (resp_fire_s) begin
          bready_d = 1'b0;
          rready_d = 1'b0;
          valid_d  = 1'b1;
          rdata_d  = write_q ? 32'd0 : load_extract(rdata, addr_q[1:0], size_q, sext_q);
          state_d  = S_DONE;
        end else begin
          state_d = state_q;
        end
      end
      S_DONE: begin
        if (lsu2dcu_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        ready_d   = 1'b1;
        valid_d   = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= 32'd0;
      size_q    <= 2'd0;
      write_q   <= 1'b0;
      sext_q    <= 1'b0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      rdata_q   <= 32'd0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      write_q   <= write_d;
      sext_q    <= sext_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      rdata_q   <= rdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
    end
  end

`ifdef DCU_ALIGN_CHECK_EN
  // Report misaligned requests that are being completed without a bus access.
  always_ff @(posedge clock) begin
    if (!reset && state_q == S_IDLE && lsu2dcu_valid && misalign_s) begin
      $error("dcu: misaligned access at addr %h", dcu_addr);
    end
  end
`endif

  assign dcu2lsu_ready = ready_q;
  assign dcu2lsu_valid = valid_q;
  assign dcu_rdata     = rdata_q;
  assign awvalid       = awvalid_q;
  assign awaddr        = addr_q;
  assign awsize        = {1'b0, size_q};
  assign awlen         = 8'd0;
  assign awburst       = 2'b01;
  assign wvalid        = wvalid_q;
  assign wdata         = wdata_q;
  assign wstrb         = wstrb_q;
  assign wlast         = 1'b1;
  assign bready        = bready_q;
  assign arvalid       = arvalid_q;
  assign araddr        = addr_q;
  assign arsize        = {1'b0, size_q};
  assign arlen         = 8'd0;
  assign arburst       = 2'b01;
  assign rready        = rready_q;

endmodule

// File: tb/tb_dcu.sv
// Self-checking bench for dcu: directed vector table, hand-written reset sequence and
// randomized accesses against a byte-lane arithmetic reference model.
module tb_dcu;

  logic        clock = 1'b0;
  logic        reset;
  logic        lsu2dcu_valid, dcu2lsu_ready;
  logic [31:0] dcu_addr;
  logic [1:0]  dcu_size;
  logic        dcu_write, dcu_sext;
  logic [31:0] dcu_wdata;
  logic        dcu2lsu_valid, lsu2dcu_ready;
  logic [31:0] dcu_rdata;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  always #5 clock = ~clock;

  dcu dut (
    .clock(clock), .reset(reset),
    .lsu2dcu_valid(lsu2dcu_valid), .dcu2lsu_ready(dcu2lsu_ready),
    .dcu_addr(dcu_addr), .dcu_size(dcu_size), .dcu_write(dcu_write),
    .dcu_sext(dcu_sext), .dcu_wdata(dcu_wdata),
    .dcu2lsu_valid(dcu2lsu_valid), .lsu2dcu_ready(lsu2dcu_ready), .dcu_rdata(dcu_rdata),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awsize(awsize),
    .awlen(awlen), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsize(arsize),
    .arlen(arlen), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  int total = 0;
  int bad   = 0;

  // Results of the most recent access, filled in by run_access.
  logic [31:0] r_rdata, r_awaddr, r_araddr, r_wdata;
  logic [3:0]  r_wstrb;
  logic [2:0]  r_awsize, r_arsize;
  int          r_lat, r_vcyc, r_aw, r_w, r_b, r_ar, r_r, r_perr;
  logic        r_done;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wr;
    logic        sx;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [31:0] e_rdata;
    logic [31:0] e_wdata;
    logic [3:0]  e_strb;
    int          awd;
    int          wdl;
    int          stall;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: byte-lane arithmetic straight from the access rules.
  function automatic logic [31:0] model_load(input logic [31:0] rd, input int off, input int size,
                                             input logic sx);
    longint v;
    int     nb;
    if (size >= 2) return rd;
    nb = (size == 0) ? 8 : 16;
    v  = (longint'(rd) >> (8 * off)) & ((64'd1 << nb) - 64'd1);
    if (sx && v >= (64'd1 << (nb - 1))) v = v - (64'd1 << nb);
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_strb(input int size, input int off);
    int nbytes;
    int m;
    nbytes = (size >= 2) ? 4 : (1 << size);
    m = (((1 << nbytes) - 1) << off) & 15;
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input int off);
    longint v;
    v = longint'(wd) << (8 * off);
    return v[31:0];
  endfunction

  task automatic idle_inputs();
    lsu2dcu_valid = 1'b0; dcu_addr = 32'd0; dcu_size = 2'd0; dcu_write = 1'b0;
    dcu_sext = 1'b0; dcu_wdata = 32'd0; lsu2dcu_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'd0;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b0;
  endtask

  // Issue one request and act as slave (with per-channel wait counts) and as LSU.
  task automatic run_access(input logic [31:0] addr, input logic [1:0] size, input logic wr,
                            input logic sx, input logic [31:0] wd, input logic [31:0] rd,
                            input int awd, input int wdl, input int bd, input int ard,
                            input int rdl, input int stall);
    int          aw_n, w_n, b_n, ar_n, r_n, st_n;
    logic [31:0] held, rnd;
    logic        prev_aw, prev_w, prev_ar;
    aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0; st_n = 0;
    prev_aw = 1'b0; prev_w = 1'b0; prev_ar = 1'b0; held = 32'd0;
    r_lat = 0; r_vcyc = 0; r_aw = 0; r_w = 0; r_b = 0; r_ar = 0; r_r = 0; r_perr = 0;
    r_done = 1'b0; r_rdata = 32'hxxxx_xxxx;
    r_awaddr = 32'd0; r_araddr = 32'd0; r_wdata = 32'd0; r_wstrb = 4'd0;
    r_awsize = 3'd0; r_arsize = 3'd0;
    @(negedge clock);
    if (dcu2lsu_ready !== 1'b1) r_perr++;
    lsu2dcu_valid = 1'b1; dcu_addr = addr; dcu_size = size; dcu_write = wr;
    dcu_sext = sx; dcu_wdata = wd;
    @(negedge clock);
    lsu2dcu_valid = 1'b0; dcu_addr = $urandom; dcu_wdata = $urandom; dcu_sext = ~sx;
    for (int cyc = 1; cyc <= 60 && !r_done; cyc++) begin
      if (cyc == 1 && (wr ? !(awvalid && wvalid) : !arvalid)) r_perr++;
      if ((prev_aw && !awvalid) || (prev_w && !wvalid) || (prev_ar && !arvalid)) r_perr++;
      if (dcu2lsu_ready !== 1'b0) r_perr++;
      awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
      if (awvalid) begin
        awready = (aw_n >= awd); aw_n++;
        if (awready) begin
          r_aw++; r_awaddr = awaddr; r_awsize = awsize;
          if (awlen !== 8'd0 || awburst !== 2'b01) r_perr++;
        end
      end
      if (wvalid) begin
        wready = (w_n >= wdl); w_n++;
        if (wready) begin
          r_w++; r_wdata = wdata; r_wstrb = wstrb;
          if (wlast !== 1'b1) r_perr++;
        end
      end
      if (arvalid) begin
        arready = (ar_n >= ard); ar_n++;
        if (arready) begin
          r_ar++; r_araddr = araddr; r_arsize = arsize;
          if (arlen !== 8'd0 || arburst !== 2'b01) r_perr++;
        end
      end
      rnd = $urandom;
      bresp = rnd[1:0]; rresp = rnd[3:2]; rlast = 1'b1;
      if (bready) begin
        bvalid = (b_n >= bd); b_n++;
        if (bvalid) r_b++;
      end
      if (rready) begin
        rvalid = (r_n >= rdl); r_n++;
        rdata = rvalid ? rd : $urandom;
        if (rvalid) r_r++;
      end
      if (dcu2lsu_valid) begin
        if (r_vcyc == 0) begin
          r_lat = cyc; held = dcu_rdata;
        end else if (dcu_rdata !== held) begin
          r_perr++;
        end
        r_vcyc++;
        lsu2dcu_ready = (st_n >= stall); st_n++;
        if (lsu2dcu_ready) r_done = 1'b1;
      end else begin
        lsu2dcu_ready = (stall == 0);
      end
      prev_aw = awvalid && !awready;
      prev_w  = wvalid && !wready;
      prev_ar = arvalid && !arready;
      @(negedge clock);
    end
    r_rdata = held;
    if (r_done && dcu2lsu_valid !== 1'b0) r_perr++;
    idle_inputs();
  endtask

  task automatic check_txn(input logic [31:0] addr, input logic [1:0] size, input logic wr,
                           input int awd, input int wdl, input int bd, input int ard,
                           input int rdl, input int stall, input logic [31:0] e_rdata,
                           input logic [31:0] e_wdata, input logic [3:0] e_strb);
    int e_lat;
    e_lat = wr ? (3 + ((awd > wdl) ? awd : wdl) + bd) : (3 + ard + rdl);
    check("completed", {31'd0, r_done}, 32'd1);
    check("rdata", r_rdata, e_rdata);
    check("latency", 32'(r_lat), 32'(e_lat));
    check("valid_cycles", 32'(r_vcyc), 32'(stall + 1));
    check("protocol_errors", 32'(r_perr), 32'd0);
    if (wr) begin
      check("aw_handshakes", 32'(r_aw), 32'd1);
      check("w_handshakes", 32'(r_w), 32'd1);
      check("b_handshakes", 32'(r_b), 32'd1);
      check("ar_handshakes", 32'(r_ar), 32'd0);
      check("awaddr", r_awaddr, addr);
      check("awsize", {29'd0, r_awsize}, {30'd0, size});
      check("wdata", r_wdata, e_wdata);
      check("wstrb", {28'd0, r_wstrb}, {28'd0, e_strb});
    end else begin
      check("ar_handshakes", 32'(r_ar), 32'd1);
      check("r_handshakes", 32'(r_r), 32'd1);
      check("aw_handshakes", 32'(r_aw), 32'd0);
      check("w_handshakes", 32'(r_w), 32'd0);
      check("araddr", r_araddr, addr);
      check("arsize", {29'd0, r_arsize}, {30'd0, size});
    end
  endtask

  initial begin
    logic [31:0] a, wd, rd;
    logic [1:0]  sz;
    logic        wr, sx;
    int          awd, wdl, bd, ard, rdl, st, vcnt;

    vecs[0] = '{32'h8000_0004, 2'd2, 1'b0, 1'b0, 32'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd0, 4'd0, 0, 0, 0};
    vecs[1] = '{32'h8000_0003, 2'd0, 1'b0, 1'b1, 32'd0, 32'h8012_3456, 32'hFFFF_FF80, 32'd0, 4'd0, 0, 0, 0};
    vecs[2] = '{32'h8000_0003, 2'd0, 1'b0, 1'b0, 32'd0, 32'h8012_3456, 32'h0000_0080, 32'd0, 4'd0, 0, 0, 0};
    vecs[3] = '{32'h0F00_0002, 2'd1, 1'b1, 1'b0, 32'h0000_1234, 32'd0, 32'd0, 32'h1234_0000, 4'b1100, 0, 0, 0};
    vecs[4] = '{32'h0000_1000, 2'd2, 1'b1, 1'b0, 32'hCAFE_F00D, 32'd0, 32'd0, 32'hCAFE_F00D, 4'b1111, 3, 0, 0};
    vecs[5] = '{32'h2000_0002, 2'd1, 1'b0, 1'b1, 32'd0, 32'hF00D_1234, 32'hFFFF_F00D, 32'd0, 4'd0, 0, 0, 4};
    vecs[6] = '{32'h0000_0001, 2'd0, 1'b1, 1'b0, 32'h1234_56AB, 32'd0, 32'd0, 32'h3456_AB00, 4'b0010, 0, 2, 0};
    vecs[7] = '{32'h4000_0000, 2'd1, 1'b0, 1'b0, 32'd0, 32'h0000_8001, 32'h0000_8001, 32'd0, 4'd0, 0, 0, 1};

    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_ready", {31'd0, dcu2lsu_ready}, 32'd1);
    check("reset_valids", {26'd0, dcu2lsu_valid, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    check("reset_rdata", dcu_rdata, 32'd0);
    check("reset_awaddr", awaddr, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_access(vecs[i].addr, vecs[i].size, vecs[i].wr, vecs[i].sx, vecs[i].wd, vecs[i].rd,
                 vecs[i].awd, vecs[i].wdl, 0, 0, 0, vecs[i].stall);
      check_txn(vecs[i].addr, vecs[i].size, vecs[i].wr, vecs[i].awd, vecs[i].wdl, 0, 0, 0,
                vecs[i].stall, vecs[i].e_rdata, vecs[i].e_wdata, vecs[i].e_strb);
    end

    // Reset while waiting for read data: the load must vanish without a completion.
    @(negedge clock);
    lsu2dcu_valid = 1'b1; dcu_addr = 32'h1234_5678; dcu_size = 2'd2; dcu_write = 1'b0;
    @(negedge clock);
    lsu2dcu_valid = 1'b0;
    check("rst_seq_arvalid", {31'd0, arvalid}, 32'd1);
    arready = 1'b1;
    @(negedge clock);
    arready = 1'b0;
    check("rst_seq_rready", {31'd0, rready}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_seq_ready", {31'd0, dcu2lsu_ready}, 32'd1);
    check("rst_seq_valids", {26'd0, dcu2lsu_valid, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    check("rst_seq_rdata", dcu_rdata, 32'd0);
    lsu2dcu_ready = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (dcu2lsu_valid) vcnt++;
    end
    check("rst_seq_no_completion", 32'(vcnt), 32'd0);
    idle_inputs();

    for (int n = 0; n < 40; n++) begin
      a   = $urandom;
      sz  = 2'($urandom_range(0, 2));
      wr  = 1'($urandom_range(0, 1));
      sx  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      rd  = $urandom;
      awd = $urandom_range(0, 3); wdl = $urandom_range(0, 3); bd = $urandom_range(0, 2);
      ard = $urandom_range(0, 2); rdl = $urandom_range(0, 2); st = $urandom_range(0, 2);
      run_access(a, sz, wr, sx, wd, rd, awd, wdl, bd, ard, rdl, st);
      check_txn(a, sz, wr, awd, wdl, bd, ard, rdl, st,
                wr ? 32'd0 : model_load(rd, int'(a[1:0]), int'(sz), sx),
                model_wdata(wd, int'(a[1:0])), model_strb(int'(sz), int'(a[1:0])));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
